// File: rtl/letc_core_pkg.sv
// Shared core types and helpers.
// Holds the M-extension multiply op encoding and multiplier latency.
package letc_core_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  localparam int MUL_LATENCY = 5;

  function automatic logic mul_rs1_signed(mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic mul_rs2_signed(mul_op_e op);
    return op == MULH;
  endfunction

  // 0x80000000 maps onto itself, which is the right unsigned magnitude
  function automatic word_t mul_mag(word_t x, logic sgn);
    return (sgn && x[31]) ? word_t'(-x) : x;
  endfunction

endpackage

// File: rtl/letc_core_mul_ctrl.sv
// Execute-stage sequencer for MUL/MULH/MULHSU/MULHU around the
// pipelined unsigned 32x32->64 multiplier.
module letc_core_mul_ctrl
  import letc_core_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_req_valid,
  output logic           o_req_ready,
  input  mul_op_e        i_req_op,
  input  word_t          i_rs1,
  input  word_t          i_rs2,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output word_t          o_rsp_result,
  input  logic           i_flush,
  output logic           o_mul_valid,
  output word_t [1:0]    o_mul_operands,
  input  logic           i_mul_valid,
  input  word_t          i_mul_result_upper,
  input  word_t          i_mul_result_lower,
  output logic           o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } state_e;

  state_e      state;
  state_e      state_n;
  logic [2:0]  quiet_cnt;
  word_t       mag1;
  word_t       mag2;
  word_t       result;
  logic        negate;
  logic        sel_upper;
  logic        quiet;
  logic        mul_done;
  logic        accept;
  logic [63:0] prod;
  word_t       prod_word;
  logic        s1;
  logic        s2;

  assign quiet    = quiet_cnt == 3'd0;
  // products arriving while quiet_cnt runs are leftovers from before reset
  assign mul_done = i_mul_valid & quiet;
  assign s1       = mul_rs1_signed(i_req_op);
  assign s2       = mul_rs2_signed(i_req_op);

  always_comb begin
    prod = {i_mul_result_upper, i_mul_result_lower};
    if (negate) begin
      prod = -prod;
    end
    prod_word = sel_upper ? prod[63:32] : prod[31:0];
  end

  always_comb begin
    state_n     = state;
    o_req_ready = 1'b0;
    o_mul_valid = 1'b0;
    o_rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        o_req_ready = quiet & ~i_flush;
        if (i_req_valid & quiet & ~i_flush) begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        o_mul_valid = ~i_flush;
        state_n     = i_flush ? IDLE : WAIT;
      end
      WAIT: begin
        if (i_flush) begin
          state_n = mul_done ? IDLE : DRAIN;
        end else if (mul_done) begin
          state_n = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_flush | i_rsp_ready) begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (mul_done) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (i_rst) begin
      o_req_ready = 1'b0;
      o_mul_valid = 1'b0;
      o_rsp_valid = 1'b0;
    end
  end

  assign accept         = i_req_valid & o_req_ready;
  assign o_rsp_result   = i_rst ? '0 : result;
  assign o_mul_operands = i_rst ? '0 : {mag2, mag1};
  assign o_busy         = ~i_rst & ((state != IDLE) | ~quiet);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      quiet_cnt <= 3'(MUL_LATENCY);
      mag1      <= '0;
      mag2      <= '0;
      result    <= '0;
      negate    <= 1'b0;
      sel_upper <= 1'b0;
    end else begin
      state <= state_n;
      if (!quiet) begin
        quiet_cnt <= quiet_cnt - 3'd1;
      end
      if (accept) begin
        mag1      <= mul_mag(i_rs1, s1);
        mag2      <= mul_mag(i_rs2, s2);
        negate    <= (s1 & i_rs1[31]) ^ (s2 & i_rs2[31]);
        sel_upper <= i_req_op != MUL;
      end
      if ((state == WAIT) && mul_done && !i_flush) begin
        result <= prod_word;
      end
    end
  end

`ifndef SYNTHESIS
  logic [MUL_LATENCY-1:0] issue_hist;
  logic                   hold_q;
  word_t                  result_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      issue_hist <= '0;
      hold_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      issue_hist <= {issue_hist[MUL_LATENCY-2:0], o_mul_valid};
      hold_q     <= o_rsp_valid & ~i_rsp_ready;
      result_q   <= o_rsp_result;
      if (issue_hist[MUL_LATENCY-1]) begin
        assert (i_mul_valid)
          else $error("multiplier result missing");
      end
      if (quiet && i_mul_valid) begin
        assert (issue_hist[MUL_LATENCY-1])
          else $error("multiplier result without issue");
      end
      if (quiet && ((state == IDLE) || (state == RESP))) begin
        assert (!i_mul_valid)
          else $error("multiplier result in idle/resp");
      end
      if (hold_q) begin
        assert (o_rsp_result == result_q)
          else $error("result changed under backpressure");
      end
    end
  end
`endif

endmodule
